// File: rtl/i4001_rom_port_arbiter.sv
// ROM BRAM owner: the i4001 fetch bus has priority, the host port gets slots outside fetch windows.
// Host writes reach the BRAM only when I4001_ROM_HOST_WRITE_EN is defined.
module i4001_rom_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              sysclk,
  input  logic              poc,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_busy,
  output logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err
);

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_HADDR = 2'd1,
    S_HDATA = 2'd2
  } state_t;

`ifdef I4001_ROM_HOST_WRITE_EN
  localparam bit WrEn = 1'b1;
`else
  localparam bit WrEn = 1'b0;
  logic unused_wdata;
  assign unused_wdata = ^host_wdata;
`endif

  state_t            state_q, state_d;
  logic              prev_cpu_q;
  logic [DATA_W-1:0] rom_data_q;
  logic              host_ack_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              host_err_q;

  always_comb begin
    state_d   = state_q;
    mem_addr  = cpu_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      S_CPU: begin
        // the ack term forces an idle cycle between host accesses
        if (host_req && !cpu_busy && !host_ack_q)
          state_d = S_HADDR;
      end
      S_HADDR: begin
        mem_addr = host_addr;
`ifdef I4001_ROM_HOST_WRITE_EN
        mem_we    = host_we;
        mem_wdata = host_we ? host_wdata : '0;
`endif
        state_d = S_HDATA;
      end
      S_HDATA: state_d = S_CPU;
      default: state_d = S_CPU;
    endcase
  end

  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      state_q      <= S_CPU;
      prev_cpu_q   <= 1'b1;
      rom_data_q   <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      host_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_cpu_q <= (state_q == S_CPU);
      host_ack_q <= (state_q == S_HDATA);
      // mem_rdata is only a CPU word when the previous address was the CPU's
      if (state_q == S_CPU && prev_cpu_q)
        rom_data_q <= mem_rdata;
      if (state_q == S_HDATA) begin
        host_err_q <= host_we && !WrEn;
        if (!host_we)
          host_rdata_q <= mem_rdata;
      end
    end
  end

  assign rom_data   = rom_data_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign host_err   = host_err_q;

endmodule

// File: tb/tb_i4001_rom_port_arbiter.sv
// Bench for i4001_rom_port_arbiter: directed scenarios then randomized host/CPU traffic.
// Expectations come from a reference ROM image and the documented cycle rules.
module tb_i4001_rom_port_arbiter;

`ifdef I4001_ROM_HOST_WRITE_EN
  localparam bit WrEn = 1'b1;
`else
  localparam bit WrEn = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        poc = 1'b1;
  logic [11:0] cpu_addr = '0;
  logic        cpu_busy = 1'b0;
  logic [7:0]  rom_data;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [11:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_err;

  i4001_rom_port_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .sysclk(sysclk), .poc(poc),
    .cpu_addr(cpu_addr), .cpu_busy(cpu_busy), .rom_data(rom_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_err(host_err)
  );

  always #5 sysclk = ~sysclk;

  logic [7:0] ref_mem [4096];
  logic [7:0] bmem [4096];
  logic       sync_mem = 1'b1;
  logic       we_seen = 1'b0;

  // BRAM model, one-cycle read latency, preloaded from the reference image
  always @(posedge sysclk) begin
    if (sync_mem) begin
      for (int i = 0; i < 4096; i++) bmem[i] <= ref_mem[i];
    end else if (mem_we) begin
      bmem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= bmem[mem_addr];
    if (mem_we === 1'b1) we_seen = 1'b1;
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // One host access; grant follows the edge after busy drops,
  // ack is visible 2 edges after grant.
  task automatic do_access(input string tag, input logic we,
                           input logic [11:0] a, input logic [7:0] wd,
                           input int busy);
    logic       ok;
    logic [7:0] rd;
    logic       err;
    int         cyc;
    ok = 1'b0; rd = '0; err = 1'b0; cyc = 0;
    cpu_busy = (busy > 0);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    while (!ok && cyc < busy + 10) begin
      @(posedge sysclk);
      #1;
      cyc++;
      if (cyc == busy) cpu_busy = 1'b0;
      if (host_ack) begin
        ok = 1'b1; rd = host_rdata; err = host_err;
      end
    end
    host_req = 1'b0;
    cpu_busy = 1'b0;
    check({tag, "_ack"}, ok, 1);
    check({tag, "_lat"}, cyc, busy + 3);
    if (!we) begin
      check({tag, "_rdata"}, rd, ref_mem[a]);
      check({tag, "_err"}, err, 0);
    end else begin
      check({tag, "_werr"}, err, !WrEn);
      if (WrEn) ref_mem[a] = wd;
    end
  endtask

  int t1, t2, cyc;
  logic [11:0] ra;
  logic [7:0] rd1;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    ref_mem[12'h1A5] = 8'h3C;
    ref_mem[12'h2F0] = 8'h96;
    ref_mem[12'h3C3] = 8'hC7;
    ref_mem[12'h055] = 8'hA5;
    ref_mem[12'h010] = 8'h77;

    idle(3);
    check("rst_rom_data", rom_data, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_host_err", host_err, 0);
    check("rst_mem_we", mem_we, 0);
    poc = 1'b0;
    sync_mem = 1'b0;
    idle(2);

    cpu_addr = 12'h1A5;
    idle(1);
    check("fetch_no_ack", host_ack, 0);
    idle(1);
    check("fetch_rom_data", rom_data, 8'h3C);

    cpu_addr = 12'h3C3;
    do_access("hread", 1'b0, 12'h2F0, 8'h00, 0);
    check("hread_rom_hold", rom_data, 8'h3C);
    idle(2);
    check("hread_rom_refresh", rom_data, 8'hC7);

    do_access("blocked_wr", 1'b1, 12'h010, 8'h5A, 20);
    idle(1);
    do_access("blocked_rb", 1'b0, 12'h010, 8'h00, 0);

    idle(1);
    ra = 12'h123;
    host_req = 1'b1; host_we = 1'b1; host_addr = ra; host_wdata = ref_mem[ra];
    idle(1);
    check("mid_mem_we", mem_we, WrEn);
    check("mid_mem_addr", mem_addr, ra);
    poc = 1'b1;
    #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_ack", host_ack, 0);
    check("mid_rst_rom", rom_data, 0);
    @(posedge sysclk);
    #1;
    poc = 1'b0;
    host_req = 1'b0;
    do_access("post_rst", 1'b0, 12'h2F0, 8'h00, 0);
    idle(2);

    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h2F0;
    cpu_addr = 12'h055;
    cyc = 0; t1 = -1; t2 = -1;
    while (t1 < 0 && cyc < 10) begin
      idle(1); cyc++;
      if (host_ack) t1 = cyc;
    end
    check("b2b_ack1", t1 >= 0, 1);
    check("b2b_rd1", host_rdata, ref_mem[12'h2F0]);
    check("b2b_rom1", rom_data, 8'hC7);
    host_addr = 12'h1A5;
    while (t2 < 0 && cyc < 20) begin
      idle(1); cyc++;
      if (host_ack) t2 = cyc;
    end
    host_req = 1'b0;
    check("b2b_ack2", t2 >= 0, 1);
    check("b2b_gap", (t2 - t1) >= 4, 1);
    check("b2b_rd2", host_rdata, ref_mem[12'h1A5]);
    check("b2b_rom2", rom_data, ref_mem[12'h055]);

    for (int k = 0; k < 30; k++) begin
      idle(1);
      ra = 12'($urandom);
      rd1 = 8'($urandom);
      do_access("rnd", 1'($urandom), ra, rd1, $urandom_range(0, 5));
      ra = 12'($urandom);
      cpu_addr = ra;
      idle(2);
      check("rnd_fetch", rom_data, ref_mem[ra]);
    end

    check("mem_we_seen", we_seen, WrEn);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i4001_rom_port_arbiter.md
# i4001_rom_port_arbiter

Sole owner of the single-port block RAM that backs the shared i4001 ROM bus. The MCS-4 fetch path (the wired-OR `rom_addr` bus from all i4001 instances) has absolute priority. A host-side loader/debug port gets read and write slots only while the CPU is outside its fetch window. The block sits between the i4001 instances and the ROM BRAM and replaces the direct `rom_addr`→BRAM connection.

## Interface
- `ADDR_W`, 12: ROM address width (4-bit chip number + 8-bit offset).
- `DATA_W`, 8: ROM word width.
- `sysclk`  in  1  system clock, all logic on rising edge.
- `poc`  in  1  reset, asynchronous, active-high.
- `cpu_addr`  in  ADDR_W  wired-OR `rom_addr` bus from the i4001 instances.
- `cpu_busy`  in  1  high while any i4001 may sample `rom_data` (A3 through M2), from timing recovery.
- `rom_data`  out  DATA_W  registered ROM word to the i4001 instances.
- `mem_addr`  out  ADDR_W  BRAM address.
- `mem_we`  out  1  BRAM write enable.
- `mem_wdata`  out  DATA_W  BRAM write data.
- `mem_rdata`  in  DATA_W  BRAM read data, one-cycle latency.
- `host_req`  in  1  host request, held until `host_ack`.
- `host_we`  in  1  1 = write, 0 = read; stable while `host_req` is high.
- `host_addr`  in  ADDR_W  host address; stable while `host_req` is high.
- `host_wdata`  in  DATA_W  host write data; stable while `host_req` is high.
- `host_ack`  out  1  one-cycle completion pulse.
- `host_rdata`  out  DATA_W  read result, valid with `host_ack` and held until the next ack.
- `host_err`  out  1  valid with `host_ack`; 1 = request rejected.

## Operation
- States are S_CPU, S_HADDR and S_HDATA. Reset state is S_CPU.
- S_CPU:
  - `mem_addr`=`cpu_addr`, `mem_we`=0.
  - `rom_data` <= `mem_rdata` every cycle whose previous cycle was also S_CPU. This gives a CPU read latency of 2 sysclk from `cpu_addr` to `rom_data`.
  - Go to S_HADDR when `host_req` && !`cpu_busy` && `host_ack`==0. The `host_ack` term enforces a one-cycle gap after each ack.
- S_HADDR:
  - `mem_addr`=`host_addr`.
  - For a write: `mem_we`=1 and `mem_wdata`=`host_wdata`.
  - Always go to S_HDATA.
- S_HDATA:
  - `mem_addr`=`cpu_addr`, `mem_we`=0.
  - Pulse `host_ack`. On a read, capture `host_rdata`<=`mem_rdata`.
  - Go to S_CPU.
- `rom_data` is never loaded in S_HADDR or S_HDATA, nor in the first S_CPU cycle after S_HDATA. During these cycles it holds its last CPU value.
- `cpu_busy` rising during S_HADDR or S_HDATA does not abort the host access; the access completes.
  - Integration guarantee: `cpu_busy` rises ≥4 sysclk before the first i4001 sample. A host slot therefore never corrupts a fetch.
- `host_req` while `cpu_busy`=1: the request waits in S_CPU with no timeout. Host latency is unbounded by design.
- `host_req` dropped before ack violates the protocol. If the FSM has already left S_CPU, it completes the access anyway.
- Reset values: S_CPU, `rom_data`=0, `host_rdata`=0, `host_ack`=0, `host_err`=0, `mem_we`=0.
- Reset mid-access (S_HADDR with `mem_we`=1) clears `mem_we` immediately (asynchronous). The BRAM write is then undefined and the host retries.
- Widths: no arithmetic. Addresses pass through unmodified with no wrap handling.

## Timing
- CPU path: `cpu_addr` sampled at edge N; `mem_rdata` valid after N+1; `rom_data` updated at N+2.
- Host path: a grant at edge G enters S_HADDR; `host_ack` is high in cycle G+2, so 2 cycles from grant to ack.
- Back-to-back host accesses need at least 4 cycles each because of the mandatory S_CPU refresh cycle and the ack gap.
- All outputs are registered except `mem_addr`, `mem_we` and `mem_wdata`, which decode directly from the state register.

## Configuration
- Macro: `I4001_ROM_HOST_WRITE_EN`.
- Defined: host writes proceed as described above.
- Undefined:
  - `mem_we` is tied to 0 and `mem_wdata` to 0.
  - A host write still passes through S_HADDR and S_HDATA, with `host_ack`=1 and `host_err`=1; BRAM is unchanged.
  - Host reads are unaffected, with `host_err`=0.

## Test plan
- CPU fetch: after reset, drive `cpu_addr`=12'h1A5 with a BRAM model holding 8'h3C -> `rom_data`=8'h3C exactly 2 sysclk later, with `host_ack` staying 0.
- Host read: `cpu_busy`=0, read at 12'h2F0 holding 8'h96 -> `host_ack` pulses 2 cycles after grant with `host_rdata`=8'h96, `host_err`=0; `rom_data` is unchanged during the access.
- Host write blocked by CPU: `cpu_busy`=1 with a write of 8'h5A to 12'h010 pending -> no grant for 20 cycles. Drop `cpu_busy` -> ack arrives within 3 cycles; a follow-up read returns 8'h5A (macro defined).
- Write disabled: without `I4001_ROM_HOST_WRITE_EN`, write 8'hFF to 12'h010 -> `host_ack`=1 with `host_err`=1, `mem_we` is never asserted, and a readback returns the old value.
- Reset mid-access: assert `poc` asynchronously during S_HADDR of a write -> `mem_we`, `host_ack` and `rom_data` go to 0 in the same cycle, and the FSM resumes in S_CPU after release.
- Back-to-back: hold `host_req` for two consecutive reads -> the two `host_ack` pulses are ≥4 cycles apart, and `rom_data` refreshes from `cpu_addr` between them.
